// File: rtl/la_ctrl_counter_pkg.sv
// ---------------------------------------------------------------------------
// la_ctrl_counter_pkg
// Shared definitions for the LA-controlled counter: the FSM state type and
// the bit positions used on the 128-bit logic analyzer buses.
// ---------------------------------------------------------------------------
package la_ctrl_counter_pkg;

    // Encoding is visible to firmware on la_data_out[34:33], so it is fixed.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    // LA input map (management SoC -> block)
    localparam int PRELOAD_LSB = 0;
    localparam int THRESH_LSB  = 32;
    localparam int RUN_BIT     = 64;
    localparam int CLR_BIT     = 65;

    // LA output map (block -> management SoC)
    localparam int DONE_BIT    = 32;
    localparam int STATE_LSB   = 33;
    localparam int WRAP_BIT    = 35;

    localparam int LA_W        = 128;

endpackage

// File: rtl/la_ctrl_counter_rise.sv
// ---------------------------------------------------------------------------
// la_rise_detect
// One-bit registered rising-edge detector. rise_o is high for the single
// cycle in which d_i is 1 and was 0 at the previous clock edge.
//
// Ports:
//   clock   in   user clock
//   resetb  in   synchronous active-low reset
//   d_i     in   level input to watch
//   rise_o  out  one-cycle pulse on a 0->1 transition of d_i
// ---------------------------------------------------------------------------
module la_rise_detect (
    input  logic clock,
    input  logic resetb,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    // Remember last cycle's level so a held-high input fires only once.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/la_ctrl_counter.sv
// ---------------------------------------------------------------------------
// la_ctrl_counter
// 32-bit counter controlled by firmware through the logic analyzer. Firmware
// can run/pause it, clear it, preload any subset of bits and set a stop
// threshold. Count and status come back on la_data_out, and count[15:0] is
// driven onto the user pads for the chip-level checkpoint monitor.
//
// Ports:
//   clock        in   1    user clock, all state updates on rising edge
//   resetb       in   1    synchronous active-low reset
//   la_data_in   in   128  [31:0] preload, [63:32] threshold, [64] run,
//                          [65] clear
//   la_oenb      in   128  per-bit LA enable, 0 = SoC drives that bit
//   la_data_out  out  128  [31:0] count, [32] done, [34:33] state,
//                          [35] wrap, all other bits 0
//   io_out       out  38   count[15:0] on [IO_LSB+15:IO_LSB], else 0
//   io_oeb       out  38   active-low pad enables
// ---------------------------------------------------------------------------
module la_ctrl_counter
    import la_ctrl_counter_pkg::*;
#(
    parameter int COUNT_W = 32,
    parameter int IO_LSB  = 16,
    parameter int IO_W    = 38
) (
    input  logic              clock,
    input  logic              resetb,
    input  logic [LA_W-1:0]   la_data_in,
    input  logic [LA_W-1:0]   la_oenb,
    output logic [LA_W-1:0]   la_data_out,
    output logic [IO_W-1:0]   io_out,
    output logic [IO_W-1:0]   io_oeb
);

    state_e               state_q, state_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic                 done_q, done_d;
    logic                 wrap_q, wrap_d;
    logic                 ioEn_q;

    logic                 runReq;
    logic                 clrReq;
    logic                 clrRise;
    logic                 incEn;
    logic [COUNT_W-1:0]   thresh;
    logic [COUNT_W-1:0]   incVal;
    logic [COUNT_W-1:0]   countNext;
    logic [COUNT_W-1:0]   preMask;
    logic                 unusedLaBits;

    // Control bits only count when the SoC actually owns them; a floating
    // LA line must never start or clear the counter.
    assign runReq = la_data_in[RUN_BIT] & ~la_oenb[RUN_BIT];
    assign clrReq = la_data_in[CLR_BIT] & ~la_oenb[CLR_BIT];

    // A partially driven threshold is treated as "no threshold" so the
    // counter cannot stop on a half-defined value.
    assign thresh = (la_oenb[THRESH_LSB +: COUNT_W] == '0)
                  ? la_data_in[THRESH_LSB +: COUNT_W]
                  : '1;

    // Clear acts on its rising edge only, so holding it high clears once.
    la_rise_detect uClrEdge (
        .clock  (clock),
        .resetb (resetb),
        .d_i    (clrReq),
        .rise_o (clrRise)
    );

    // Increment only while running with run still asserted; the cycle that
    // run drops is the pause cycle and does not count.
    assign incEn  = (state_q == RUN) && runReq;
    assign incVal = incEn ? (count_q + COUNT_W'(1)) : count_q;

    // Per-bit preload: a SoC-driven bit replaces the counter bit in every
    // state, so firmware can force values even while DONE.
    assign preMask   = ~la_oenb[PRELOAD_LSB +: COUNT_W];
    assign countNext = (la_data_in[PRELOAD_LSB +: COUNT_W] & preMask)
                     | (incVal & ~preMask);

    // Next-state logic. Clear rise outranks everything; the threshold is
    // compared against the value about to be loaded, so a threshold equal
    // to the entry count is only hit after a full wrap.
    always_comb begin
        state_d = state_q;
        count_d = countNext;
        done_d  = done_q;
        wrap_d  = wrap_q;

        if (clrRise) begin
            state_d = IDLE;
            count_d = '0;
            done_d  = 1'b0;
            wrap_d  = 1'b0;
        end else begin
            if (incEn && (count_q == '1)) begin
                wrap_d = 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (runReq) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (!runReq) begin
                        state_d = PAUSE;
                    end else if (countNext == thresh) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
                PAUSE: begin
                    if (runReq) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    if (!runReq) begin
                        state_d = IDLE;
                        done_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State registers. ioEn_q keeps the pads tri-stated while in reset and
    // enables them from the first edge after reset is released.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            state_q <= IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
            ioEn_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
            ioEn_q  <= 1'b1;
        end
    end

    // Outputs come straight from registers, so they are valid right after
    // the edge with no extra pipeline stage.
    always_comb begin
        la_data_out                          = '0;
        la_data_out[PRELOAD_LSB +: COUNT_W]  = count_q;
        la_data_out[DONE_BIT]                = done_q;
        la_data_out[STATE_LSB +: 2]          = state_q;
        la_data_out[WRAP_BIT]                = wrap_q;
    end

    always_comb begin
        io_out                = '0;
        io_out[IO_LSB +: 16]  = count_q[15:0];
        io_oeb                = '1;
        if (ioEn_q) begin
            io_oeb[IO_LSB +: 16] = '0;
        end
    end

    // Upper LA bits are not part of the map.
    assign unusedLaBits = ^{la_data_in[LA_W-1:CLR_BIT+1], la_oenb[LA_W-1:CLR_BIT+1]};

endmodule

// File: tb/tb_la_ctrl_counter.sv
// ---------------------------------------------------------------------------
// tb_la_ctrl_counter
// Self-checking bench for la_ctrl_counter: directed scenarios from the test
// plan followed by a randomized run compared against a behavioural model.
// ---------------------------------------------------------------------------
module tb_la_ctrl_counter;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

    logic           clock  = 1'b0;
    logic           resetb = 1'b0;
    logic [127:0]   laIn   = '0;
    logic [127:0]   laOenb = '1;
    logic [127:0]   laOut;
    logic [37:0]    ioOut;
    logic [37:0]    ioOeb;

    int nChecks = 0;
    int nFails  = 0;

    // Behavioural model of the firmware-visible state.
    bit [31:0] mCount = '0;
    int        mState = S_IDLE;
    bit        mDone  = 1'b0;
    bit        mWrap  = 1'b0;
    bit        mClrQ  = 1'b0;
    bit        mIoEn  = 1'b0;

    la_ctrl_counter dut (
        .clock       (clock),
        .resetb      (resetb),
        .la_data_in  (laIn),
        .la_oenb     (laOenb),
        .la_data_out (laOut),
        .io_out      (ioOut),
        .io_oeb      (ioOeb)
    );

    always #5 clock = ~clock;

    // Advance the model by one clock edge using the inputs present now.
    task automatic stepModel();
        bit        run, clr, rise, inc;
        bit [31:0] thr, base, nxt, own;
        if (!resetb) begin
            mCount = '0; mState = S_IDLE; mDone = 0; mWrap = 0; mClrQ = 0; mIoEn = 0;
            return;
        end
        run  = laIn[64] && !laOenb[64];
        clr  = laIn[65] && !laOenb[65];
        thr  = (laOenb[63:32] == 32'h0) ? laIn[63:32] : 32'hFFFF_FFFF;
        rise = clr && !mClrQ;
        mClrQ = clr;
        mIoEn = 1'b1;
        if (rise) begin
            mCount = '0; mState = S_IDLE; mDone = 0; mWrap = 0;
            return;
        end
        inc  = (mState == S_RUN) && run;
        base = inc ? 32'((longint'(mCount) + 1) % 64'h1_0000_0000) : mCount;
        if (inc && base == 32'h0) mWrap = 1'b1;
        own  = ~laOenb[31:0];
        nxt  = (laIn[31:0] & own) | (base & ~own);
        case (mState)
            S_IDLE:  if (run) mState = S_RUN;
            S_RUN: begin
                if (!run) mState = S_PAUSE;
                else if (nxt == thr) begin mState = S_DONE; mDone = 1'b1; end
            end
            S_PAUSE: if (run) mState = S_RUN;
            default: if (!run) begin mState = S_IDLE; mDone = 1'b0; end
        endcase
        mCount = nxt;
    endtask

    task automatic tick();
        stepModel();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        resetb = 1'b0;
        laIn   = '0;
        laOenb = '1;
        repeat (10) tick();
        nChecks++;
        if (laOut !== 128'h0) begin
            nFails++; $display("[TB] FAIL reset_laout: got %h expected 0", laOut);
        end
        nChecks++;
        if (ioOeb !== {38{1'b1}}) begin
            nFails++; $display("[TB] FAIL reset_ioeb: got %h expected %h", ioOeb, {38{1'b1}});
        end
        nChecks++;
        if (ioOut !== 38'h0) begin
            nFails++; $display("[TB] FAIL reset_ioout: got %h expected 0", ioOut);
        end
        resetb = 1'b1;
        tick();
        nChecks++;
        if (ioOeb !== {6'h3F, 16'h0000, 16'hFFFF}) begin
            nFails++; $display("[TB] FAIL post_reset_ioeb: got %h expected %h", ioOeb, {6'h3F, 16'h0000, 16'hFFFF});
        end
        nChecks++;
        if (ioOut[31:16] !== 16'h0000 || laOut !== 128'h0) begin
            nFails++; $display("[TB] FAIL post_reset_out: mprj %h la %h expected 0", ioOut[31:16], laOut);
        end
    endtask

    // Drive run=1 and count RUN-state edges until done rises (bounded).
    task automatic runUntilDone(input int budget, output int runCycles, output bit gotDone);
        logic [1:0] prevState;
        runCycles = 0;
        gotDone   = 1'b0;
        for (int c = 0; c < budget; c++) begin
            prevState = laOut[34:33];
            tick();
            if (prevState == 2'd1) runCycles++;
            if (laOut[32]) begin gotDone = 1'b1; break; end
        end
    endtask

    task automatic test_threshold();
        int runCycles; bit gotDone;
        laOenb[65:32] = '0;
        laIn[65]      = 1'b0;
        laIn[63:32]   = 32'h0000_AB40;
        laIn[64]      = 1'b1;
        runUntilDone(50000, runCycles, gotDone);
        nChecks++;
        if (!gotDone || runCycles != 32'hAB40) begin
            nFails++; $display("[TB] FAIL thresh_cycles: done %0d after %0d run cycles, required %0d", gotDone, runCycles, 32'hAB40);
        end
        nChecks++;
        if (laOut[35:0] !== {1'b0, 2'd3, 1'b1, 32'h0000_AB40}) begin
            nFails++; $display("[TB] FAIL thresh_status: got %h expected %h", laOut[35:0], {1'b0, 2'd3, 1'b1, 32'h0000_AB40});
        end
        for (int c = 0; c < 100; c++) begin
            tick();
            nChecks++;
            if (ioOut[31:16] !== 16'hAB40 || laOut[34:33] !== 2'd3) begin
                nFails++; $display("[TB] FAIL thresh_hold: mprj %h state %0d, expected ab40 state 3", ioOut[31:16], laOut[34:33]);
            end
        end
    endtask

    task automatic test_preload();
        logic [1:0] prevState;
        int runCycles = 0; bit gotDone = 0;
        laIn[64] = 1'b0;
        tick();
        laOenb[31:0] = '0;
        laIn[31:0]   = 32'h0000_AB30;
        tick();
        nChecks++;
        if (laOut[31:0] !== 32'h0000_AB30 || laOut[34:33] !== 2'd0) begin
            nFails++; $display("[TB] FAIL preload_load: count %h state %0d, expected ab30 state 0", laOut[31:0], laOut[34:33]);
        end
        laOenb[31:0] = '1;
        laIn[31:0]   = '0;
        laIn[63:32]  = 32'h0000_AB41;
        laIn[64]     = 1'b1;
        for (int c = 0; c < 100 && !gotDone; c++) begin
            prevState = laOut[34:33];
            tick();
            if (prevState == 2'd1) begin
                runCycles++;
                nChecks++;
                if (laOut[31:0] !== 32'h0000_AB30 + 32'(runCycles)) begin
                    nFails++; $display("[TB] FAIL preload_step: got %h expected %h", laOut[31:0], 32'h0000_AB30 + 32'(runCycles));
                end
            end
            gotDone = laOut[32];
        end
        nChecks++;
        if (!gotDone || runCycles != 17 || laOut[31:0] !== 32'h0000_AB41) begin
            nFails++; $display("[TB] FAIL preload_done: done %0d run cycles %0d count %h, required 1 17 ab41", gotDone, runCycles, laOut[31:0]);
        end
    endtask

    task automatic test_wrap();
        int runCycles; bit gotDone;
        laIn[64] = 1'b0;
        tick();
        laOenb[31:0] = '0;
        laIn[31:0]   = 32'hFFFF_FFFE;
        tick();
        laOenb[31:0] = '1;
        laIn[63:32]  = 32'h0000_0001;
        laIn[64]     = 1'b1;
        runUntilDone(100, runCycles, gotDone);
        nChecks++;
        if (!gotDone || runCycles != 3) begin
            nFails++; $display("[TB] FAIL wrap_cycles: done %0d after %0d run cycles, required 3", gotDone, runCycles);
        end
        nChecks++;
        if (laOut[35:0] !== {1'b1, 2'd3, 1'b1, 32'h0000_0001}) begin
            nFails++; $display("[TB] FAIL wrap_status: got %h expected %h", laOut[35:0], {1'b1, 2'd3, 1'b1, 32'h0000_0001});
        end
    endtask

    task automatic test_pause();
        bit reached = 0;
        laIn[64]  = 1'b0;
        laIn[65]  = 1'b1;
        tick();
        nChecks++;
        if (laOut[35:0] !== 36'h0) begin
            nFails++; $display("[TB] FAIL pause_clear: got %h expected 0", laOut[35:0]);
        end
        laIn[65]      = 1'b0;
        laOenb[63:32] = '1;
        laIn[64]      = 1'b1;
        for (int c = 0; c < 100 && !reached; c++) begin
            tick();
            reached = (laOut[31:0] == 32'h10);
        end
        nChecks++;
        if (!reached) begin
            nFails++; $display("[TB] FAIL pause_reach: count %h never reached 10", laOut[31:0]);
        end
        laIn[64] = 1'b0;
        for (int c = 0; c < 21; c++) begin
            tick();
            nChecks++;
            if (laOut[31:0] !== 32'h10 || laOut[34:33] !== 2'd2) begin
                nFails++; $display("[TB] FAIL pause_hold: count %h state %0d, expected 10 state 2", laOut[31:0], laOut[34:33]);
            end
        end
        laIn[64] = 1'b1;
        tick();
        tick();
        nChecks++;
        if (laOut[31:0] !== 32'h11 || laOut[34:33] !== 2'd1) begin
            nFails++; $display("[TB] FAIL pause_resume: count %h state %0d, expected 11 state 1", laOut[31:0], laOut[34:33]);
        end
    endtask

    task automatic test_clear_hold();
        int runCycles; bit gotDone;
        laOenb[63:32] = '0;
        laIn[63:32]   = 32'h15;
        runUntilDone(100, runCycles, gotDone);
        nChecks++;
        if (!gotDone || laOut[31:0] !== 32'h15) begin
            nFails++; $display("[TB] FAIL clear_setup: done %0d count %h, expected 1 15", gotDone, laOut[31:0]);
        end
        laIn[65] = 1'b1;
        tick();
        nChecks++;
        if (laOut[35:0] !== 36'h0) begin
            nFails++; $display("[TB] FAIL clear_first: got %h expected 0", laOut[35:0]);
        end
        tick();
        nChecks++;
        if (laOut[34:33] !== 2'd1 || laOut[31:0] !== 32'h0) begin
            nFails++; $display("[TB] FAIL clear_rerun: state %0d count %h, expected 1 0", laOut[34:33], laOut[31:0]);
        end
        for (int c = 1; c <= 3; c++) begin
            tick();
            nChecks++;
            if (laOut[31:0] !== 32'(c) || laOut[34:33] !== 2'd1) begin
                nFails++; $display("[TB] FAIL clear_held: count %h state %0d, expected %h state 1", laOut[31:0], laOut[34:33], c);
            end
        end
        laIn[65] = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [127:0] expLa;
        logic [37:0]  expIo, expOeb;
        for (int c = 0; c < 4000; c++) begin
            resetb = ($urandom_range(0, 149) != 0);
            laIn   = {$urandom, $urandom, $urandom, $urandom};
            laOenb = '1;
            laIn[64] = ($urandom_range(0, 9) != 0);
            laIn[65] = ($urandom_range(0, 14) == 0);
            laOenb[64] = ($urandom_range(0, 19) == 0);
            laOenb[65] = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) != 0) begin
                laOenb[63:32] = '0;
                laIn[63:32]   = mCount + 32'($urandom_range(0, 8));
            end else if ($urandom_range(0, 1) == 0) begin
                laOenb[63:32] = $urandom;
            end
            case ($urandom_range(0, 39))
                0: laOenb[31:0] = '0;
                1: laOenb[31:0] = $urandom;
                2: begin laOenb[31:0] = '0; laIn[31:0] = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)); end
                default: laOenb[31:0] = '1;
            endcase
            tick();
            expLa         = '0;
            expLa[31:0]   = mCount;
            expLa[32]     = mDone;
            expLa[34:33]  = 2'(mState);
            expLa[35]     = mWrap;
            expIo         = {6'b0, mCount[15:0], 16'b0};
            expOeb        = mIoEn ? {6'h3F, 16'h0000, 16'hFFFF} : {38{1'b1}};
            nChecks++;
            if (laOut !== expLa) begin
                nFails++; $display("[TB] FAIL rand_laout cycle %0d: got %h expected %h", c, laOut, expLa);
            end
            nChecks++;
            if (ioOut !== expIo || ioOeb !== expOeb) begin
                nFails++; $display("[TB] FAIL rand_io cycle %0d: out %h oeb %h expected %h %h", c, ioOut, ioOeb, expIo, expOeb);
            end
        end
        resetb = 1'b1;
    endtask

    initial begin
        $display("[TB] starting la_ctrl_counter bench");
        test_reset();
        test_threshold();
        test_preload();
        test_wrap();
        test_pause();
        test_clear_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
